// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: fetches one instruction over a
// req/ready handshake, holds it for decode, and picks the next PC at commit.
module pc_fetch_unit #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int              TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic             inst_valid,
    input  logic             inst_ack,
    input  logic             branch,
    input  logic             jalr,
    input  logic             zero,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [31:0]      instret,
    output logic             fault
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              valid_q, valid_d;
    logic [31:0]       instret_q, instret_d;
    logic              fault_q, fault_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              taken_s;
    logic [WIDTH-1:0]  nt_s;
    logic [WIDTH-1:0]  seq_pc_s;

    assign seq_pc_s = pc_q + PC_STEP;
    assign taken_s  = branch & zero;
    assign nt_s     = jalr ? {target[WIDTH-1:1], 1'b0} : target;

    // Next-state and next-output computation for the fetch FSM
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        valid_d   = valid_q;
        instret_d = instret_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_REQ: begin
                // req is registered low out of reset, so the first REQ cycle only raises it
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ready) begin
                    inst_d  = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_VALID;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_VALID: begin
                if (inst_ack) begin
                    instret_d = instret_q + 32'd1;
                    valid_d   = 1'b0;
                    if (taken_s && nt_s[1]) begin
                        fault_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = taken_s ? nt_s : seq_pc_s;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_VALID;
                end
            end
            S_FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                fault_d = 1'b1;
                state_d = S_FAULT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            req_q     <= 1'b0;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            valid_q   <= 1'b0;
            instret_q <= 32'd0;
            fault_q   <= 1'b0;
            cnt_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
            cnt_q     <= cnt_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_plus4   = seq_pc_s;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign instret    = instret_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: sequential fetch, branches,
// jalr alignment, stalls, timeout fault and asynchronous reset.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ack;
    logic        branch;
    logic        jalr;
    logic        zero;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;
    logic        fault;

    int n_pass = 0;
    int n_total = 0;

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ack(inst_ack),
        .branch(branch), .jalr(jalr), .zero(zero), .target(target),
        .pc(pc), .pc_plus4(pc_plus4), .instret(instret), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1;
        imem_ready = 1'b0; imem_rdata = 32'd0; inst_ack = 1'b0;
        branch = 1'b0; jalr = 1'b0; zero = 1'b0; target = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for a request, check address, stall ready, then return one word.
    task automatic do_fetch(input logic [31:0] exp_addr, input int rdy_delay,
                            input logic [31:0] word);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (imem_req !== 1'b1) $display("FAIL fetch_req_wait: imem_req=%b required 1", imem_req);
        else n_pass++;
        n_total++;
        if (imem_addr !== exp_addr) $display("FAIL fetch_addr: got %h required %h", imem_addr, exp_addr);
        else n_pass++;
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge clk);
            n_total++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr || inst_valid !== 1'b0)
                $display("FAIL stall_req_hold: req=%b addr=%h valid=%b required 1 %h 0",
                         imem_req, imem_addr, inst_valid, exp_addr);
            else n_pass++;
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
        n_total++;
        if (inst_valid !== 1'b1 || inst !== word || imem_req !== 1'b0)
            $display("FAIL fetch_capture: valid=%b inst=%h req=%b required 1 %h 0",
                     inst_valid, inst, imem_req, word);
        else n_pass++;
    endtask

    // Hold without ack, then commit with the given branch inputs.
    task automatic do_commit(input int ack_delay, input logic br, input logic jr,
                             input logic z, input logic [31:0] tgt,
                             input logic [31:0] exp_instret);
        logic [31:0] inst_hold, pc_hold;
        inst_hold = inst;
        pc_hold   = pc;
        for (int i = 0; i < ack_delay; i++) begin
            branch = 1'b1; zero = 1'b1; target = 32'hDEAD_0000;
            @(negedge clk);
            n_total++;
            if (inst_valid !== 1'b1 || inst !== inst_hold || pc !== pc_hold)
                $display("FAIL ack_hold: valid=%b inst=%h pc=%h required 1 %h %h",
                         inst_valid, inst, pc, inst_hold, pc_hold);
            else n_pass++;
        end
        inst_ack = 1'b1; branch = br; jalr = jr; zero = z; target = tgt;
        @(negedge clk);
        inst_ack = 1'b0; branch = 1'b0; jalr = 1'b0; zero = 1'b0;
        n_total++;
        if (instret !== exp_instret || inst_valid !== 1'b0)
            $display("FAIL commit_instret: instret=%0d valid=%b required %0d 0",
                     instret, inst_valid, exp_instret);
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        #1;
        n_total++;
        if (imem_req !== 1'b0 || pc !== 32'd0 || instret !== 32'd0 || fault !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'd0)
            $display("FAIL reset_state: req=%b pc=%h instret=%0d fault=%b valid=%b inst=%h required 0 0 0 0 0 0",
                     imem_req, pc, instret, fault, inst_valid, inst);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0)
            $display("FAIL reset_release_req: req=%b addr=%h required 1 0", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_fetch(32'h0, 0, 32'h0000_0013); do_commit(0, 1'b0, 1'b0, 1'b1, 32'h100, 32'd1);
        do_fetch(32'h4, 0, 32'h0010_0093); do_commit(0, 1'b0, 1'b0, 1'b1, 32'h100, 32'd2);
        do_fetch(32'h8, 0, 32'h0020_0113); do_commit(0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd3);
        n_total++;
        if (imem_addr !== 32'hC || pc_plus4 !== 32'h10 || instret !== 32'd3)
            $display("FAIL seq_pc: addr=%h pc_plus4=%h instret=%0d required c 10 3",
                     imem_addr, pc_plus4, instret);
        else n_pass++;
    endtask

    task automatic test_branch();
        do_fetch(32'hC, 0, 32'h0000_0063);   do_commit(0, 1'b1, 1'b0, 1'b1, 32'h20, 32'd4);
        do_fetch(32'h20, 0, 32'h0000_0063);  do_commit(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'd5);
        do_fetch(32'h100, 0, 32'h0000_0063); do_commit(0, 1'b1, 1'b0, 1'b1, 32'h20, 32'd6);
        do_fetch(32'h20, 0, 32'h0000_0063);  do_commit(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd7);
        n_total++;
        if (imem_addr !== 32'h24) $display("FAIL branch_not_taken: addr=%h required 24", imem_addr);
        else n_pass++;
    endtask

    task automatic test_jalr_and_stall();
        do_fetch(32'h24, 0, 32'h0000_0067); do_commit(0, 1'b1, 1'b1, 1'b1, 32'h205, 32'd8);
        n_total++;
        if (imem_addr !== 32'h204) $display("FAIL jalr_clear_bit0: addr=%h required 204", imem_addr);
        else n_pass++;
        do_fetch(32'h204, 5, 32'hABCD_1234);
        do_commit(10, 1'b0, 1'b0, 1'b0, 32'h0, 32'd9);
        do_fetch(32'h208, 0, 32'h0000_0067); do_commit(0, 1'b1, 1'b1, 1'b1, 32'h206, 32'd10);
        n_total++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h208 || inst_valid !== 1'b0)
            $display("FAIL jalr_misaligned: fault=%b req=%b pc=%h valid=%b required 1 0 208 0",
                     fault, imem_req, pc, inst_valid);
        else n_pass++;
        imem_ready = 1'b1; inst_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ready = 1'b0; inst_ack = 1'b0;
        n_total++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || instret !== 32'd10 || inst_valid !== 1'b0)
            $display("FAIL fault_sticky: fault=%b req=%b instret=%0d valid=%b required 1 0 10 0",
                     fault, imem_req, instret, inst_valid);
        else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (fault !== 1'b0 || imem_req !== 1'b1)
                $display("FAIL timeout_early: cycle %0d fault=%b req=%b required 0 1", i, fault, imem_req);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if (fault !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL timeout_fault: fault=%b req=%b required 1 0", fault, imem_req);
        else n_pass++;
        imem_ready = 1'b1; imem_rdata = 32'h1111_2222; inst_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ready = 1'b0; inst_ack = 1'b0;
        n_total++;
        if (fault !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'd0 || instret !== 32'd0)
            $display("FAIL timeout_sticky: fault=%b valid=%b inst=%h instret=%0d required 1 0 0 0",
                     fault, inst_valid, inst, instret);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_fetch(32'h0, 0, 32'h0000_006F); do_commit(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'd1);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40)
            $display("FAIL async_setup: req=%b addr=%h required 1 40", imem_req, imem_addr);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (imem_req !== 1'b0 || pc !== 32'd0 || instret !== 32'd0 || fault !== 1'b0)
            $display("FAIL async_reset: req=%b pc=%h instret=%0d fault=%b required 0 0 0 0",
                     imem_req, pc, instret, fault);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        do_fetch(32'h0, 1, 32'h0000_0013);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jalr_and_stall();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
